// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter and its round-robin picker.
// The package is also used by the lock-timeout logic that is enabled with
// MEM_ARB_LOCK_TIMEOUT_EN.
package mem_arb_pkg;

   // Transaction sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2,
      ST_LOCKED = 2'd3
   } arb_state_e;

   // Number of cycles a locked owner may sit in IDLE-LOCKED before it is evicted.
   localparam logic [7:0] LOCK_TIMEOUT = 8'd255;

   // Requester index width. It is never zero, so a single requester still has a 1-bit index.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. It selects the first set request, searching
// upward from ptr_i and wrapping at N. The I/O port arbiter reuses this block.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   // Index of the k-th candidate, counted from the pointer with wrap.
   function automatic logic [IW-1:0] slot(input logic [IW-1:0] p, input int k);
      int s;
      s = (int'(p) + k) % int'(N);
      return IW'(s);
   endfunction

   // Priority-rotate search: the first hit wins and later candidates are masked.
   always_comb begin
      // NOTE: every output gets a default before the loop so that no path leaves it unassigned (no latch).
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int k = 0; k < int'(N); k++) begin
         if (!valid_o && req_i[slot(ptr_i, k)]) begin
            valid_o               = 1'b1;
            gnt_o[slot(ptr_i, k)] = 1'b1;
            idx_o                 = slot(ptr_i, k);
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one RAM port between NUM_REQ requesters.
// Each access runs IDLE -> ACCESS -> ACK. A requester can hold a bus lock so that
// it can perform atomic read-modify-write sequences.
// Define MEM_ARB_LOCK_TIMEOUT_EN to add a 255-cycle lock watchdog and the lock_err_o port.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned AW      = 8,
   parameter int unsigned DW      = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic [NUM_REQ-1:0]    req_i,
   input  logic [NUM_REQ-1:0]    req_we_i,
   input  logic [NUM_REQ-1:0]    req_lock_i,
   input  logic [NUM_REQ*AW-1:0] req_addr_i,
   input  logic [NUM_REQ*DW-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]    gnt_o,
   output logic [NUM_REQ-1:0]    ack_o,
   output logic [DW-1:0]         rdata_o,
   output logic [AW-1:0]         mem_addr_o,
   output logic [DW-1:0]         mem_wdata_o,
   output logic                  mem_we_o,
   output logic                  mem_en_o,
   input  logic [DW-1:0]         mem_rdata_i
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
   ,
   output logic                  lock_err_o
`endif
);

   localparam int unsigned IW = idx_width(NUM_REQ);

   arb_state_e          state_q;
   logic [NUM_REQ-1:0]  gnt_q;
   logic [NUM_REQ-1:0]  ack_q;
   logic [DW-1:0]       rdata_q;
   logic [AW-1:0]       mem_addr_q;
   logic [DW-1:0]       mem_wdata_q;
   logic                mem_we_q;
   logic                mem_en_q;
   logic                txn_we_q;
   logic [IW-1:0]       rr_ptr_q;
   logic [IW-1:0]       owner_q;
   logic [IW-1:0]       rr_next_d;

   logic [NUM_REQ-1:0]  pick_gnt;
   logic [IW-1:0]       pick_idx;
   logic                pick_valid;

   logic [IW-1:0]       sel_idx;
   logic                sel_we;
   logic [AW-1:0]       sel_addr;
   logic [DW-1:0]       sel_wdata;
   logic                owner_req;
   logic                owner_lock;

`ifdef MEM_ARB_LOCK_TIMEOUT_EN
   logic [7:0]          lock_cnt_q;
   logic                lock_err_q;
`endif

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr_pick (
      .req_i   (req_i),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // The pointer moves one past the owner that is leaving, so that owner drops to lowest priority.
   assign rr_next_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

   // Mux the request fields of the requester that will own the next access, and the owner's req/lock levels.
   always_comb begin
      sel_idx    = (state_q == ST_IDLE) ? pick_idx : owner_q;
      sel_we     = 1'b0;
      sel_addr   = '0;
      sel_wdata  = '0;
      owner_req  = 1'b0;
      owner_lock = 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (sel_idx == IW'(i)) begin
            sel_we    = req_we_i[i];
            sel_addr  = req_addr_i[i*AW +: AW];
            sel_wdata = req_wdata_i[i*DW +: DW];
         end
         if (owner_q == IW'(i)) begin
            owner_req  = req_i[i];
            owner_lock = req_lock_i[i];
         end
      end
   end

   // Transaction sequencer. All bus outputs are registered in this block.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         // NOTE: reset clears every output register at once, so a transaction aborted by reset never produces an ack.
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         ack_q       <= '0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         txn_we_q    <= 1'b0;
         rr_ptr_q    <= '0;
         owner_q     <= '0;     // owner_q is meaningful only outside ST_IDLE
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
         lock_cnt_q  <= '0;
         lock_err_q  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout; every register updates from pre-edge values.
         ack_q <= '0;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
         lock_err_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (pick_valid) begin
                  gnt_q       <= pick_gnt;
                  owner_q     <= pick_idx;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= sel_we;
                  mem_addr_q  <= sel_addr;
                  mem_wdata_q <= sel_wdata;
                  txn_we_q    <= sel_we;
                  state_q     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               mem_en_q <= 1'b0;
               mem_we_q <= 1'b0;
               ack_q    <= gnt_q;
               state_q  <= ST_ACK;
            end
            ST_ACK: begin
               if (!txn_we_q) begin
                  rdata_q <= mem_rdata_i;
               end
               if (owner_lock) begin
                  state_q <= ST_LOCKED;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
                  lock_cnt_q <= '0;
`endif
               end else begin
                  rr_ptr_q <= rr_next_d;
                  gnt_q    <= '0;
                  state_q  <= ST_IDLE;
               end
            end
            ST_LOCKED: begin
               if (owner_req) begin
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= sel_we;
                  mem_addr_q  <= sel_addr;
                  mem_wdata_q <= sel_wdata;
                  txn_we_q    <= sel_we;
                  state_q     <= ST_ACCESS;
               end else if (!owner_lock) begin
                  rr_ptr_q <= rr_next_d;
                  gnt_q    <= '0;
                  state_q  <= ST_IDLE;
               end
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
               else if (lock_cnt_q == LOCK_TIMEOUT - 8'd1) begin
                  rr_ptr_q   <= rr_next_d;
                  gnt_q      <= '0;
                  lock_err_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end else begin
                  lock_cnt_q <= lock_cnt_q + 8'd1;
               end
`endif
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // RAM read data is valid during the ACK cycle. It is passed through in that cycle and held afterwards.
   assign rdata_o     = (state_q == ST_ACK && !txn_we_q) ? mem_rdata_i : rdata_q;
   assign gnt_o       = gnt_q;
   assign ack_o       = ack_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_we_o    = mem_we_q;
   assign mem_en_o    = mem_en_q;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
   assign lock_err_o  = lock_err_q;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Round-robin arbiter that shares the computer's single 8-bit RAM port between NUM_REQ requesters (CPU fetch/execute, I/O DMA, debug loader).
- Sits between the requesters and the RAM macro.
- Sequences each access as a 3-state transaction: grant, memory cycle, acknowledge.
- Supports a bus-lock so one master can perform atomic read-modify-write sequences.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AW, 8, address width.
- DW, 8, data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester access request, level, held until ack.
- req_we  in  NUM_REQ  per-requester write enable, valid with req.
- req_lock  in  NUM_REQ  per-requester lock: keep grant after ack.
- req_addr  in  NUM_REQ*AW  flattened addresses; requester i uses slice [i*AW +: AW].
- req_wdata  in  NUM_REQ*DW  flattened write data.
- gnt  out  NUM_REQ  one-hot current owner, all-zero when idle.
- ack  out  NUM_REQ  one-cycle pulse, transaction complete.
- rdata  out  DW  read data, valid in the ack cycle, shared by all requesters.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_we  out  1  RAM write strobe.
- mem_en  out  1  RAM enable.
- mem_rdata  in  DW  RAM read data, registered, one cycle after mem_en.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; gnt=0, ack=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rr_ptr=0; lock_owner invalid.
- IDLE:
  - If any req is set, pick the first set requester searching from rr_ptr upward with wrap.
  - Register gnt one-hot and go to ACCESS.
  - No req set: stay in IDLE with gnt=0.
- ACCESS (1 cycle):
  - mem_en=1; mem_addr, mem_we and mem_wdata are taken from the granted slice, registered at entry.
  - Next state is ACK.
- ACK (1 cycle):
  - ack[owner]=1.
  - On reads, rdata=mem_rdata, captured on this edge and held until the next ACK.
  - On writes, rdata holds its previous value.
  - mem_en=0, mem_we=0.
- Lock handling on leaving ACK:
  - If req_lock[owner]=1: keep gnt, stay owner, go to IDLE-LOCKED. Other requests are ignored.
  - Otherwise: rr_ptr=owner+1 (mod NUM_REQ), gnt=0, go to IDLE.
- IDLE-LOCKED:
  - Owner req=1: go to ACCESS with the same grant.
  - Owner req=0 and req_lock=0: release, advance rr_ptr, go to IDLE.
  - Owner req=0 and req_lock=1: stay in IDLE-LOCKED.
- Latency and throughput:
  - req→ack is 3 cycles (IDLE, ACCESS, ACK).
  - Back-to-back locked accesses: 3 cycles each. Max throughput is 1 access per 3 cycles.
- Requester handshake: drop req in the cycle after ack, or keep it high to issue another access. A new access is sampled in the next IDLE.
- Misbehaving requester: dropping req mid-transaction has no effect. The transaction completes and ack still pulses.
- Simultaneous requests: only one gnt bit is ever set. Starvation-free — every requester is served within NUM_REQ transactions, absent lock.
- Reset mid-transaction: immediate abort to reset values; no ack is issued.
- NUM_REQ=1 degenerates to a pass-through sequencer.

Optional Feature:
- Macro: MEM_ARB_LOCK_TIMEOUT_EN.
- With it defined:
  - An 8-bit counter counts cycles spent in IDLE-LOCKED.
  - At 255 the lock is forcibly released: rr_ptr advances, output lock_err pulses for 1 cycle, and gnt is cleared.
  - Adds port lock_err out 1, reset value 0.
- Without it: no counter, no lock_err port; a lock is held indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - State encoding localparams: ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_ACK=2'd2, ST_LOCKED=2'd3.
  - LOCK_TIMEOUT=8'd255.
- Sub-module rr_pick (combinational priority rotate):
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot gnt_next and an index.
  - Reused by the I/O port arbiter.

Test Plan:
- Reset then a single write: req[0]=1, we=1, addr=0x10, wdata=0xA5 → mem_en and mem_we high in cycle 2, ack[0] in cycle 3; a later read of 0x10 from req[2] returns rdata=0xA5 with ack[2].
- All four req high continuously, no lock → grants in order 0,1,2,3,0, each ack exactly 3 cycles apart; gnt never multi-hot.
- Lock: req[1] with lock=1 performs read 0x20 then write 0x20=0x21 while req[0] and req[3] are held high → no grant to 0 or 3 until req_lock[1] drops; the next grant goes to 3 if rr_ptr=2.
- Reset asserted in the ACCESS cycle → all outputs 0 asynchronously, no ack; after release, a pending req[2] is granted first, since rr_ptr=0 and it is the only request.
- With MEM_ARB_LOCK_TIMEOUT_EN: req[0] locks then idles with lock=1 → lock_err pulses after 255 IDLE-LOCKED cycles, gnt=0, and waiting req[1] is granted next cycle.
